regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter CORES, default 4: number of cores issuing writeback requests.
REQ-002 Parameter DEPTH, default 2: entries per core queue (power of 2, >=2).
REQ-003 Parameter DATA_W, default 32: register data width.
REQ-004 Parameter ADDR_W, default 5: register index width.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port reset_n, input, 1: synchronous, active-low reset, sampled on rising clk.
REQ-007 Port req_valid, input, CORES: per-core writeback request valid.
REQ-008 Port req_addr, input, CORES*ADDR_W: per-core destination register; core i in slice i.
REQ-009 Port req_data, input, CORES*DATA_W: per-core write data; core i in slice i.
REQ-010 Port req_ready, output, CORES: per-core queue can accept this cycle.
REQ-011 Port wb_en, output, 1: registered regfile write strobe.
REQ-012 Port wb_addr, output, ADDR_W: registered register index.
REQ-013 Port wb_data, output, DATA_W: registered write data.
REQ-014 Port wb_core, output, clog2(CORES): index of the core whose write is presented.
REQ-015 Port wb_ready, input, 1: regfile accepts the presented write this cycle.

Function
REQ-016 Core i transfer occurs when req_valid[i] && req_ready[i] on a rising edge.
REQ-017 req_ready[i] SHALL equal (queue i count < DEPTH), from registered count only; no same-cycle pop credit.
REQ-018 Each queue SHALL be FIFO; per-core write order on wb_* SHALL equal acceptance order.
REQ-019 Output stage is loadable when wb_en==0 or (wb_en && wb_ready).
REQ-020 When loadable, arbiter SHALL pop one non-empty queue into the output register; else output holds.
REQ-021 Selection: round-robin, search starting at (last_grant+1) mod CORES; last_grant updates only on pop.
REQ-022 A loadable cycle with all queues empty SHALL clear wb_en; wb_addr/wb_data/wb_core keep last values.
REQ-023 Latency: request accepted into empty system at edge N SHALL appear with wb_en=1 after edge N+1.
REQ-024 Throughput: with wb_ready held 1 and requests pending, one write per cycle.
REQ-025 wb_en, wb_addr, wb_data, wb_core SHALL hold stable while wb_en && !wb_ready.
REQ-026 Simultaneous push and pop on the same queue SHALL leave count unchanged; pointers wrap mod DEPTH.
REQ-027 No request is dropped or duplicated except as per REQ-031.

Reset
REQ-028 On reset_n==0 at an edge: all counts/pointers 0, req_ready all 1 on the next cycle, wb_en=0, wb_addr=0, wb_data=0, wb_core=0, last_grant=CORES-1.
REQ-029 Reset mid-operation SHALL discard all queued and presented writes; no wb_en pulse on the reset cycle's output.

Configuration
REQ-030 Macro WB_ZERO_FILTER_EN selects register-0 filtering.
REQ-031 Defined: accepted requests with addr==0 are consumed (ready per REQ-017) but not enqueued, never reach wb_*.
REQ-032 Undefined: addr==0 requests are queued and written like any other.

Structure
REQ-033 Package regfile_wb_pkg SHALL hold default DATA_W, ADDR_W, CORES constants and the entry typedef {addr, data}.
REQ-034 Per-core queue SHALL be sub-module wb_core_fifo (push/pop, full/empty, count), instantiated CORES times.

Verification
REQ-035 Single write: core 2 sends addr=12 data=1 with wb_ready=1 -> one cycle later wb_en=1, wb_addr=12, wb_data=1, wb_core=2, then wb_en=0.
REQ-036 Fairness: after reset, all 4 cores send one request same cycle (addr 12..15, data 1,0,0,0), wb_ready=1 -> wb_core 0,1,2,3 on consecutive cycles, values match.
REQ-037 Backpressure: core 0 sends 3 writes (addr 1,2,3) with wb_ready=0 -> req_ready[0]=0 after 2 accepted plus 1 in output; writes emerge 1,2,3 in order once wb_ready=1, outputs stable while stalled.
REQ-038 Full queue push+pop: queue 1 full, wb_ready=1, req_valid[1]=1 -> request not accepted that cycle (req_ready[1]=0), accepted next cycle.
REQ-039 Reset mid-flight: 4 queued writes, assert reset_n=0 one cycle -> wb_en=0, all req_ready=1, none of the 4 writes appear afterwards.
REQ-040 Zero filter: core 3 writes addr=0 data=0xDEADBEEF -> with WB_ZERO_FILTER_EN no wb_en pulse; without it wb_en=1, wb_addr=0, wb_data=0xDEADBEEF.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared defaults and the queued entry layout for the regfile writeback arbiter.
// Build option: WB_ZERO_FILTER_EN drops accepted writes to register 0.
package regfile_wb_pkg;

    localparam int DEF_CORES  = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_core_fifo.sv
// Per-core writeback queue: power-of-two depth, registered count, wrap-around pointers.
module wb_core_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = $bits(wb_entry_t),
    localparam int PW   = $clog2(DEPTH),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNTW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging per-core writeback queues into one registered regfile write port.
// Build option: WB_ZERO_FILTER_EN consumes register-0 writes without queuing them.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int CORES  = DEF_CORES,
    parameter int DEPTH  = 2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    localparam int CW    = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CORES-1:0]         req_valid,
    input  logic [CORES*ADDR_W-1:0]  req_addr,
    input  logic [CORES*DATA_W-1:0]  req_data,
    output logic [CORES-1:0]         req_ready,
    output logic                     wb_en,
    output logic [ADDR_W-1:0]        wb_addr,
    output logic [DATA_W-1:0]        wb_data,
    output logic [CW-1:0]            wb_core,
    input  logic                     wb_ready
);

    localparam int EW   = ADDR_W + DATA_W;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [CORES-1:0] push;
    logic [CORES-1:0] pop;
    logic [CORES-1:0] full;
    logic [CORES-1:0] empty;
    logic [EW-1:0]    head  [CORES];
    logic [CNTW-1:0]  count [CORES];

    logic          loadable;
    logic          found;
    logic [CW-1:0] sel;
    logic [CW-1:0] idx;
    logic [CW-1:0] last_grant;

    for (genvar g = 0; g < CORES; g++) begin : g_core
        logic [ADDR_W-1:0] addr;
        logic              keep;

        assign addr = req_addr[g*ADDR_W +: ADDR_W];
`ifdef WB_ZERO_FILTER_EN
        assign keep = |addr;
`else
        assign keep = 1'b1;
`endif
        // Readiness comes from the registered count only, so a pop never frees a slot early.
        assign req_ready[g] = (count[g] < CNTW'(DEPTH));
        assign push[g]      = req_valid[g] && !full[g] && keep;

        wb_core_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (EW)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (push[g]),
            .push_data ({addr, req_data[g*DATA_W +: DATA_W]}),
            .pop       (pop[g]),
            .pop_data  (head[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .count     (count[g])
        );
    end

    assign loadable = !wb_en || wb_ready;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < CORES; k++) begin
            idx = CW'((int'(last_grant) + 1 + k) % CORES);
            if (!found && !empty[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (loadable && found) begin
            pop[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            wb_core    <= '0;
            last_grant <= CW'(CORES - 1);
        end else if (loadable) begin
            if (found) begin
                wb_en              <= 1'b1;
                {wb_addr, wb_data} <= head[sel];
                wb_core            <= sel;
                last_grant         <= sel;
            end else begin
                // Payload fields keep their last values when the port goes idle.
                wb_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-cycle vector table plus a randomly stalled stream.
module tb_regfile_wb_arbiter;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         wb_en;
    logic [4:0]   wb_addr;
    logic [31:0]  wb_data;
    logic [1:0]   wb_core;
    logic         wb_ready;

    int tests;
    int fails;

    regfile_wb_arbiter #(
        .CORES  (4),
        .DEPTH  (2),
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_core   (wb_core),
        .wb_ready  (wb_ready)
    );

    // Clock and reset-time input defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         rst_n;
        logic [3:0]   valid;
        logic [19:0]  addr;
        logic [127:0] data;
        logic         rdy;
        logic [3:0]   exp_ready;
        logic         exp_en;
        logic [4:0]   exp_addr;
        logic [31:0]  exp_data;
        logic [1:0]   exp_core;
    } vec_t;

    vec_t vecs[$];
    logic [36:0] exp_q[$];

    function automatic logic [19:0] pa(input int c, input logic [4:0] a);
        return 20'(a) << (5 * c);
    endfunction

    function automatic logic [127:0] pd(input int c, input logic [31:0] d);
        return 128'(d) << (32 * c);
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [19:0] a,
                                input logic [127:0] d, input logic wr, input logic [3:0] er,
                                input logic ee, input logic [4:0] ea, input logic [31:0] ed,
                                input logic [1:0] ec);
        vec_t x;
        x.rst_n = r;  x.valid = v;  x.addr = a;  x.data = d;  x.rdy = wr;
        x.exp_ready = er;  x.exp_en = ee;  x.exp_addr = ea;  x.exp_data = ed;  x.exp_core = ec;
        return x;
    endfunction

    // Driver: apply one vector at the falling edge
    task automatic drive(input vec_t x);
        @(negedge clk);
        reset_n   = x.rst_n;
        req_valid = x.valid;
        req_addr  = x.addr;
        req_data  = x.data;
        wb_ready  = x.rdy;
    endtask

    // Scoreboard check of one vector, one step after the rising edge
    task automatic check_vec(input int n, input vec_t x);
        tests++;
        if (req_ready !== x.exp_ready) begin
            fails++;
            $display("FAIL row%0d req_ready: got %b want %b", n, req_ready, x.exp_ready);
        end
        tests++;
        if ({wb_en, wb_addr, wb_data, wb_core} !== {x.exp_en, x.exp_addr, x.exp_data, x.exp_core}) begin
            fails++;
            $display("FAIL row%0d wb: got en=%b addr=%0d data=%h core=%0d want en=%b addr=%0d data=%h core=%0d",
                     n, wb_en, wb_addr, wb_data, wb_core, x.exp_en, x.exp_addr, x.exp_data, x.exp_core);
        end
    endtask

    initial begin
        logic        prev_stall;
        logic [39:0] prev_out;
        logic [31:0] cur_d;
        logic [36:0] e;
        int          sent;
        int          got;
        int          cyc;

        tests = 0;
        fails = 0;
        reset_n = 1'b0;  req_valid = '0;  req_addr = '0;  req_data = '0;  wb_ready = 1'b0;

        // Reset, then all four cores at once: grants 0,1,2,3 in order
        vecs.push_back(mk(0, 4'b0000, '0, '0, 0, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, {5'd15, 5'd14, 5'd13, 5'd12}, {32'd0, 32'd0, 32'd0, 32'd1},
                          1, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 1, 12, 1, 0));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 1, 13, 0, 1));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 1, 14, 0, 2));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 1, 15, 0, 3));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 0, 15, 0, 3));
        // Single write from core 2, one-cycle latency, then idle with held payload
        vecs.push_back(mk(1, 4'b0100, pa(2, 12), pd(2, 1), 1, 4'hF, 0, 15, 0, 3));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 1, 12, 1, 2));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 0, 12, 1, 2));
        // Backpressure on core 0: two queued plus one presented
        vecs.push_back(mk(1, 4'b0001, pa(0, 1), pd(0, 32'h11), 0, 4'hF, 0, 12, 1, 2));
        vecs.push_back(mk(1, 4'b0001, pa(0, 2), pd(0, 32'h22), 0, 4'hF, 1, 1, 32'h11, 0));
        vecs.push_back(mk(1, 4'b0001, pa(0, 3), pd(0, 32'h33), 0, 4'hE, 1, 1, 32'h11, 0));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 0, 4'hE, 1, 1, 32'h11, 0));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 1, 2, 32'h22, 0));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 1, 3, 32'h33, 0));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 0, 3, 32'h33, 0));
        // Full queue 1: push during pop is refused, accepted the following cycle
        vecs.push_back(mk(1, 4'b0010, pa(1, 5), pd(1, 32'h55), 0, 4'hF, 0, 3, 32'h33, 0));
        vecs.push_back(mk(1, 4'b0010, pa(1, 6), pd(1, 32'h66), 0, 4'hF, 1, 5, 32'h55, 1));
        vecs.push_back(mk(1, 4'b0010, pa(1, 7), pd(1, 32'h77), 0, 4'hD, 1, 5, 32'h55, 1));
        vecs.push_back(mk(1, 4'b0010, pa(1, 8), pd(1, 32'h88), 1, 4'hF, 1, 6, 32'h66, 1));
        vecs.push_back(mk(1, 4'b0010, pa(1, 8), pd(1, 32'h88), 1, 4'hF, 1, 7, 32'h77, 1));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 1, 8, 32'h88, 1));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 0, 8, 32'h88, 1));
        // Reset with four writes queued: everything discarded
        vecs.push_back(mk(1, 4'b1111, {5'd23, 5'd22, 5'd21, 5'd20},
                          {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 4'hF, 0, 8, 32'h88, 1));
        vecs.push_back(mk(0, 4'b0000, '0, '0, 0, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 0, 0, 0, 0));
        // Register-0 write from core 3
        vecs.push_back(mk(1, 4'b1000, pa(3, 0), pd(3, 32'hDEADBEEF), 1, 4'hF, 0, 0, 0, 0));
`ifdef WB_ZERO_FILTER_EN
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 0, 0, 0, 0));
`else
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 1, 0, 32'hDEADBEEF, 3));
        vecs.push_back(mk(1, 4'b0000, '0, '0, 1, 4'hF, 0, 0, 32'hDEADBEEF, 3));
`endif

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_vec(i, vecs[i]);
        end

        // Core 2 stream of eight writes under random wb_ready; order, stability and count checked
        sent = 0;  got = 0;  cyc = 0;
        prev_stall = 1'b0;  prev_out = '0;
        cur_d = $urandom;
        while ((sent < 8 || exp_q.size() != 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                tests++;
                if ({wb_en, wb_addr, wb_data, wb_core} !== prev_out) begin
                    fails++;
                    $display("FAIL stall_hold: got %h want %h", {wb_en, wb_addr, wb_data, wb_core}, prev_out);
                end
            end
            wb_ready = 1'($urandom_range(0, 1));
            if (wb_en && wb_ready) begin
                tests++;
                got++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: got addr=%0d data=%h want none", wb_addr, wb_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({wb_addr, wb_data} !== e || wb_core !== 2'd2) begin
                        fails++;
                        $display("FAIL stream_order: got addr=%0d data=%h core=%0d want addr=%0d data=%h core=2",
                                 wb_addr, wb_data, wb_core, e[36:32], e[31:0]);
                    end
                end
            end
            if (sent < 8) begin
                req_valid = 4'b0100;
                req_addr  = pa(2, 5'(sent + 1));
                req_data  = pd(2, cur_d);
                if (req_ready[2]) begin
                    exp_q.push_back({5'(sent + 1), cur_d});
                    sent++;
                    cur_d = $urandom;
                end
            end else begin
                req_valid = '0;
            end
            prev_stall = wb_en && !wb_ready;
            prev_out   = {wb_en, wb_addr, wb_data, wb_core};
        end
        @(negedge clk);
        req_valid = '0;
        wb_ready  = 1'b1;

        tests++;
        if (got != 8 || sent != 8) begin
            fails++;
            $display("FAIL stream_count: got %0d written %0d sent want 8 and 8 (cycles %0d)", got, sent, cyc);
        end

        repeat (2) @(negedge clk);
        tests++;
        if (wb_en !== 1'b0) begin
            fails++;
            $display("FAIL stream_drain: got wb_en=%b want 0", wb_en);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
